// File: rtl/vga_sprite_engine.sv
// VGA timing generator with a double-buffered sprite table fetched from BRAM port B.
// Define VGA_CENTER_LINE_EN to draw the dashed centre net beneath the sprites.
module vga_sprite_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int CLK_DIV     = 2,
  parameter int NUM_SPRITES = 4,
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       q_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              hSync,
  output logic              vSync,
  output logic              bright,
  output logic              enable,
  output logic              sync,
  output logic              frame_start,
  output logic              load_done
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SPR_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  typedef struct packed {
    logic       en;
    logic [2:0] color;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] w;
    logic [7:0] h;
  } sprite_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} fetch_state_e;

  logic [DIV_W-1:0]  divCnt_q, divCnt_d;
  logic              enable_q, enable_d;
  logic [10:0]       hCount_q, hCount_d;
  logic [10:0]       vCount_q, vCount_d;
  logic              hSync_q, hSync_d;
  logic              vSync_q, vSync_d;
  logic              bright_q, bright_d;
  logic [2:0]        rgb_q, rgb_d;
  fetch_state_e      state_q, state_d;
  logic [SPR_W-1:0]  sprIdx_q, sprIdx_d;
  logic [1:0]        wordIdx_q, wordIdx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pending_q, pending_d;
  logic              frameStart_q, frameStart_d;
  sprite_t           shadow_q [NUM_SPRITES];
  sprite_t           shadow_d [NUM_SPRITES];
  sprite_t           active_q [NUM_SPRITES];
  sprite_t           active_d [NUM_SPRITES];

  logic       lineEnd;
  logic       frameEnd;
  logic       wrap;
  logic       brightNow;
  logic [2:0] pixColor;

  // Bounds are widened to 11 bits so a sprite past the right/bottom edge clips instead of wrapping.
  function automatic logic spriteHit(input sprite_t s, input logic [10:0] hc, input logic [10:0] vc);
    logic [10:0] xEnd;
    logic [10:0] yEnd;
    xEnd = {1'b0, s.x} + {3'b000, s.w};
    yEnd = {1'b0, s.y} + {3'b000, s.h};
    return s.en && (s.w != 8'd0) && (s.h != 8'd0) &&
           ({1'b0, s.x} <= hc) && (hc < xEnd) &&
           ({1'b0, s.y} <= vc) && (vc < yEnd);
  endfunction

  assign lineEnd  = (hCount_q == 11'(H_TOTAL - 1));
  assign frameEnd = lineEnd && (vCount_q == 11'(V_TOTAL - 1));
  assign wrap     = enable_q && frameEnd;
  assign brightNow = (hCount_q < 11'(H_ACTIVE)) && (vCount_q < 11'(V_ACTIVE));

  always_comb begin
    divCnt_d = (divCnt_q == DIV_W'(CLK_DIV - 1)) ? '0 : divCnt_q + 1'b1;
    enable_d = (divCnt_d == DIV_W'(CLK_DIV - 1));
    hCount_d = hCount_q;
    vCount_d = vCount_q;
    if (enable_q) begin
      if (lineEnd) begin
        hCount_d = '0;
        vCount_d = frameEnd ? 11'd0 : vCount_q + 11'd1;
      end else begin
        hCount_d = hCount_q + 11'd1;
      end
    end
  end

  // Lower indices are applied last so they win; the net, if present, sits under every sprite.
  always_comb begin
    pixColor = 3'b000;
`ifdef VGA_CENTER_LINE_EN
    if (((hCount_q == 11'(H_ACTIVE / 2 - 1)) || (hCount_q == 11'(H_ACTIVE / 2))) && !vCount_q[4]) begin
      pixColor = 3'b111;
    end
`endif
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (spriteHit(active_q[i], hCount_q, vCount_q)) begin
        pixColor = active_q[i].color;
      end
    end
  end

  always_comb begin
    hSync_d  = hSync_q;
    vSync_d  = vSync_q;
    bright_d = bright_q;
    rgb_d    = rgb_q;
    if (enable_q) begin
      hSync_d  = !((hCount_q >= 11'(H_SYNC_START)) && (hCount_q < 11'(H_SYNC_END)));
      vSync_d  = !((vCount_q >= 11'(V_SYNC_START)) && (vCount_q < 11'(V_SYNC_END)));
      bright_d = brightNow;
      rgb_d    = brightNow ? pixColor : 3'b000;
    end
  end

  always_comb begin
    state_d   = state_q;
    sprIdx_d  = sprIdx_q;
    wordIdx_d = wordIdx_q;
    addr_d    = addr_q;
    shadow_d  = shadow_q;
    case (state_q)
      IDLE: begin
        if (enable_q && (hCount_q == 11'd0) && (vCount_q == 11'(V_ACTIVE))) begin
          state_d   = ISSUE;
          sprIdx_d  = '0;
          wordIdx_d = '0;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        case (wordIdx_q)
          2'd0: begin
            shadow_d[sprIdx_q].en    = q_b[15];
            shadow_d[sprIdx_q].color = q_b[14:12];
            shadow_d[sprIdx_q].x     = q_b[9:0];
          end
          2'd1: shadow_d[sprIdx_q].y = q_b[9:0];
          default: begin
            shadow_d[sprIdx_q].w = q_b[15:8];
            shadow_d[sprIdx_q].h = q_b[7:0];
          end
        endcase
        if (wordIdx_q != 2'd2) begin
          wordIdx_d = wordIdx_q + 2'd1;
          state_d   = ISSUE;
        end else if (sprIdx_q == SPR_W'(NUM_SPRITES - 1)) begin
          state_d = DONE;
        end else begin
          wordIdx_d = 2'd0;
          sprIdx_d  = sprIdx_q + 1'b1;
          state_d   = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Address is loaded on entry to ISSUE so the BRAM sees it during the ISSUE clk.
    if (state_d == ISSUE) begin
      addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(sprIdx_d) * ADDR_W'(3) + ADDR_W'(wordIdx_d);
    end
  end

  always_comb begin
    pending_d    = pending_q;
    active_d     = active_q;
    frameStart_d = wrap;
    if (wrap) begin
      pending_d = 1'b0;
      if (pending_q) begin
        active_d = shadow_q;
      end
    end
    if (state_q == DONE) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt_q     <= '0;
      enable_q     <= 1'b0;
      hCount_q     <= '0;
      vCount_q     <= '0;
      hSync_q      <= 1'b1;
      vSync_q      <= 1'b1;
      bright_q     <= 1'b0;
      rgb_q        <= 3'b000;
      state_q      <= IDLE;
      sprIdx_q     <= '0;
      wordIdx_q    <= '0;
      addr_q       <= ADDR_W'(BASE_ADDR);
      pending_q    <= 1'b0;
      frameStart_q <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      divCnt_q     <= divCnt_d;
      enable_q     <= enable_d;
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      hSync_q      <= hSync_d;
      vSync_q      <= vSync_d;
      bright_q     <= bright_d;
      rgb_q        <= rgb_d;
      state_q      <= state_d;
      sprIdx_q     <= sprIdx_d;
      wordIdx_q    <= wordIdx_d;
      addr_q       <= addr_d;
      pending_q    <= pending_d;
      frameStart_q <= frameStart_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  assign addr_b      = addr_q;
  assign VGA_R       = {8{rgb_q[2]}};
  assign VGA_G       = {8{rgb_q[1]}};
  assign VGA_B       = {8{rgb_q[0]}};
  assign hSync       = hSync_q;
  assign vSync       = vSync_q;
  assign bright      = bright_q;
  assign enable      = enable_q;
  assign sync        = 1'b0;
  assign frame_start = frameStart_q;
  assign load_done   = (state_q == DONE);

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine on a shrunken 24x17 raster so whole frames fit in a short run.
// Pixel p = v*24+h of frame F appears on the outputs after clk edge F*816 + 2*(p+1) counted from reset release.
module tb_vga_sprite_engine;

  localparam int H_ACT = 16, H_FP = 2, H_SY = 3, H_BP = 3;
  localparam int V_ACT = 12, V_FP = 1, V_SY = 2, V_BP = 2;
  localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
  localparam int FRAME = H_TOT * V_TOT * 2;
  localparam int BASE  = 8;

  logic        clk;
  logic        reset;
  logic [15:0] q_b;
  logic [15:0] addr_b;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        hSync, vSync, bright, enable, sync, frame_start, load_done;

  logic [15:0] mem [64];
  int checks = 0;
  int errors = 0;
  int edgeCount = 0;
  int loadDoneCount = 0;
  int loadDoneBase;
  logic [23:0] netColor;

  vga_sprite_engine #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .CLK_DIV(2), .NUM_SPRITES(4), .ADDR_W(16), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .q_b(q_b), .addr_b(addr_b),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .hSync(hSync), .vSync(vSync), .bright(bright), .enable(enable),
    .sync(sync), .frame_start(frame_start), .load_done(load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) q_b <= mem[addr_b[5:0]];

  always @(negedge clk) if (load_done) loadDoneCount++;

  task automatic applyStimulus(input int idx, input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    mem[BASE + 3 * idx]     = w0;
    mem[BASE + 3 * idx + 1] = w1;
    mem[BASE + 3 * idx + 2] = w2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepTo(input int n);
    if (n > edgeCount) repeat (n - edgeCount) @(posedge clk);
    edgeCount = n;
    #1;
  endtask

  function automatic int pixEdge(input int frame, input int h, input int v);
    return frame * FRAME + 2 * (v * H_TOT + h + 1);
  endfunction

  initial begin
`ifdef VGA_CENTER_LINE_EN
    netColor = 24'hFFFFFF;
`else
    netColor = 24'h000000;
`endif
    reset = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    // green 3x3 at (8,5), blue 4x3 at (9,6), red 4x3 at (3,2), yellow 16x1 at (12,9) clipped on the right
    applyStimulus(0, 16'hA008, 16'd5, 16'h0303);
    applyStimulus(1, 16'h9009, 16'd6, 16'h0403);
    applyStimulus(2, 16'hC003, 16'd2, 16'h0403);
    applyStimulus(3, 16'hE00C, 16'd9, 16'h1001);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_hSync", 32'(hSync), 32'd1);
    checkOutput("rst_vSync", 32'(vSync), 32'd1);
    checkOutput("rst_bright", 32'(bright), 32'd0);
    checkOutput("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    checkOutput("rst_addr", 32'(addr_b), 32'(BASE));
    checkOutput("rst_enable", 32'(enable), 32'd0);
    checkOutput("rst_flags", 32'({frame_start, load_done, sync}), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    edgeCount = 0;

    stepTo(1);   checkOutput("enable_hi", 32'(enable), 32'd1);
    stepTo(2);   checkOutput("enable_lo", 32'(enable), 32'd0);
                 checkOutput("bright_px0", 32'(bright), 32'd1);
    stepTo(34);  checkOutput("bright_px16", 32'(bright), 32'd0);
    stepTo(37);  checkOutput("hsync_before", 32'(hSync), 32'd1);
    stepTo(38);  checkOutput("hsync_fall", 32'(hSync), 32'd0);
    stepTo(43);  checkOutput("hsync_hold", 32'(hSync), 32'd0);
    stepTo(44);  checkOutput("hsync_rise", 32'(hSync), 32'd1);
    stepTo(580); checkOutput("addr_e0w1", 32'(addr_b), 32'(BASE + 1));
    stepTo(601); checkOutput("load_done_early", 32'(load_done), 32'd0);
    stepTo(602); checkOutput("load_done_pulse", 32'(load_done), 32'd1);
    stepTo(603); checkOutput("load_done_end", 32'(load_done), 32'd0);
                 checkOutput("addr_hold", 32'(addr_b), 32'(BASE + 11));
    stepTo(625); checkOutput("vsync_before", 32'(vSync), 32'd1);
    stepTo(626); checkOutput("vsync_fall", 32'(vSync), 32'd0);
    stepTo(721); checkOutput("vsync_hold", 32'(vSync), 32'd0);
    stepTo(722); checkOutput("vsync_rise", 32'(vSync), 32'd1);
    stepTo(815); checkOutput("fs_before", 32'(frame_start), 32'd0);
    stepTo(816); checkOutput("fs_pulse", 32'(frame_start), 32'd1);
    stepTo(817); checkOutput("fs_end", 32'(frame_start), 32'd0);

    stepTo(pixEdge(1, 2, 2));   checkOutput("px_2_2_black", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);
    stepTo(pixEdge(1, 3, 2));   checkOutput("px_3_2_red", 32'({VGA_R, VGA_G, VGA_B}), 32'hFF0000);
    stepTo(pixEdge(1, 7, 2));   checkOutput("px_7_2_black", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);
    stepTo(pixEdge(1, 3, 5));   checkOutput("px_3_5_black", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);
    stepTo(pixEdge(1, 9, 6));   checkOutput("px_9_6_green", 32'({VGA_R, VGA_G, VGA_B}), 32'h00FF00);
    stepTo(pixEdge(1, 12, 8));  checkOutput("px_12_8_blue", 32'({VGA_R, VGA_G, VGA_B}), 32'h0000FF);
    stepTo(pixEdge(1, 0, 9));   checkOutput("px_0_9_nowrap", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);
    stepTo(pixEdge(1, 12, 9));  checkOutput("px_12_9_yellow", 32'({VGA_R, VGA_G, VGA_B}), 32'hFFFF00);
    stepTo(pixEdge(1, 15, 9));  checkOutput("px_15_9_yellow", 32'({VGA_R, VGA_G, VGA_B}), 32'hFFFF00);
    stepTo(pixEdge(1, 16, 9));  checkOutput("px_16_9_bright", 32'(bright), 32'd0);
                                checkOutput("px_16_9_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);

    // Disable green before this frame's fetch; blue should surface after the next commit.
    mem[BASE] = 16'h2008;
    stepTo(2 * FRAME);          checkOutput("fs_frame2", 32'(frame_start), 32'd1);
    stepTo(pixEdge(2, 3, 2));   checkOutput("f2_px_3_2_red", 32'({VGA_R, VGA_G, VGA_B}), 32'hFF0000);
    stepTo(pixEdge(2, 9, 6));   checkOutput("f2_px_9_6_blue", 32'({VGA_R, VGA_G, VGA_B}), 32'h0000FF);

    // Abort the frame-2 fetch while entry 2 word 0 is being issued.
    stepTo(2 * FRAME + 578 + 12); checkOutput("addr_e2w0", 32'(addr_b), 32'(BASE + 6));
    reset = 1'b1;
    stepTo(2 * FRAME + 578 + 14); checkOutput("rst_mid_addr", 32'(addr_b), 32'(BASE));
    reset = 1'b0;
    edgeCount = 0;
    loadDoneBase = loadDoneCount;

    stepTo(2);   checkOutput("rs_bright_px0", 32'(bright), 32'd1);
    stepTo(38);  checkOutput("rs_hsync_fall", 32'(hSync), 32'd0);
    stepTo(pixEdge(0, 3, 2)); checkOutput("rs_px_3_2_off", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);
    stepTo(pixEdge(0, 9, 6)); checkOutput("rs_px_9_6_off", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);
    stepTo(577); checkOutput("rs_no_load_done", 32'(loadDoneCount - loadDoneBase), 32'd0);
    stepTo(603); checkOutput("rs_refetch_done", 32'(loadDoneCount - loadDoneBase), 32'd1);
    stepTo(FRAME); checkOutput("rs_fs", 32'(frame_start), 32'd1);
    stepTo(pixEdge(1, H_ACT / 2 - 1, 0)); checkOutput("net_px", 32'({VGA_R, VGA_G, VGA_B}), 32'(netColor));
    stepTo(pixEdge(1, 3, 2)); checkOutput("rs_f1_px_3_2_red", 32'({VGA_R, VGA_G, VGA_B}), 32'hFF0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
